// File: rtl/pcie_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pcie_tx_arbiter
// Brief    : Packet-atomic round-robin merge of the PIO and Ethernet TLP
//            streams into the 7-series PCIe AXIS transmit port.
// Revision : 1.0 - initial release
// ============================================================================
module pcie_tx_arbiter #(
    parameter int         C_DATA_WIDTH = 64,
    parameter int         KEEP_WIDTH   = C_DATA_WIDTH / 8,
    parameter logic [5:0] MIN_BUF_AV   = 6'd2
) (
    input  logic                    user_clk,
    input  logic                    user_reset_n,

    input  logic                    app_tx_tvalid,
    output logic                    app_tx_tready,
    input  logic                    app_tx_tlast,
    input  logic [KEEP_WIDTH-1:0]   app_tx_tkeep,
    input  logic [C_DATA_WIDTH-1:0] app_tx_tdata,
    input  logic [3:0]              app_tx_tuser,

    input  logic                    eth_tx_tvalid,
    output logic                    eth_tx_tready,
    input  logic                    eth_tx_tlast,
    input  logic [KEEP_WIDTH-1:0]   eth_tx_tkeep,
    input  logic [C_DATA_WIDTH-1:0] eth_tx_tdata,
    input  logic [3:0]              eth_tx_tuser,

    input  logic                    s_axis_tx_tready,
    output logic                    s_axis_tx_tvalid,
    output logic                    s_axis_tx_tlast,
    output logic [KEEP_WIDTH-1:0]   s_axis_tx_tkeep,
    output logic [C_DATA_WIDTH-1:0] s_axis_tx_tdata,
    output logic [3:0]              s_axis_tx_tuser,

    input  logic [5:0]              tx_buf_av,
    output logic [31:0]             pkt_cnt_app,
    output logic [31:0]             pkt_cnt_eth
);

    localparam int c_beat_w = C_DATA_WIDTH + KEEP_WIDTH + 4 + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT_APP = 2'd1,
        GRANT_ETH = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_last_grant;   // 1 = ETH was granted last
    logic [31:0]           r_pkt_cnt_app;
    logic [31:0]           r_pkt_cnt_eth;
    logic [1:0]            r_count;
    logic [c_beat_w-1:0]   r_head;
    logic [c_beat_w-1:0]   r_tail;

    logic                  w_full;
    logic                  w_buf_ok;
    logic                  w_app_fire;
    logic                  w_eth_fire;
    logic                  w_push;
    logic                  w_pop;
    logic [c_beat_w-1:0]   w_in;

    // Source ready depends only on registered state and occupancy, never on core ready.
    assign w_full        = (r_count == 2'd2);
    assign app_tx_tready = (r_state == GRANT_APP) && !w_full;
    assign eth_tx_tready = (r_state == GRANT_ETH) && !w_full;

    assign w_buf_ok   = (tx_buf_av >= MIN_BUF_AV);
    assign w_app_fire = app_tx_tvalid && app_tx_tready;
    assign w_eth_fire = eth_tx_tvalid && eth_tx_tready;
    assign w_push     = w_app_fire || w_eth_fire;
    assign w_pop      = s_axis_tx_tvalid && s_axis_tx_tready;

    assign w_in = (r_state == GRANT_ETH)
                ? {eth_tx_tdata, eth_tx_tkeep, eth_tx_tuser, eth_tx_tlast}
                : {app_tx_tdata, app_tx_tkeep, app_tx_tuser, app_tx_tlast};

    assign s_axis_tx_tvalid = (r_count != 2'd0);
    assign {s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tuser, s_axis_tx_tlast} = r_head;

    assign pkt_cnt_app = r_pkt_cnt_app;
    assign pkt_cnt_eth = r_pkt_cnt_eth;

    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            r_state       <= IDLE;
            r_last_grant  <= 1'b1;
            r_pkt_cnt_app <= 32'd0;
            r_pkt_cnt_eth <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_buf_ok) begin
                        if (app_tx_tvalid && (!eth_tx_tvalid || r_last_grant)) begin
                            r_state      <= GRANT_APP;
                            r_last_grant <= 1'b0;
                        end else if (eth_tx_tvalid) begin
                            r_state      <= GRANT_ETH;
                            r_last_grant <= 1'b1;
                        end
                    end
                end
                GRANT_APP: begin
                    if (w_app_fire && app_tx_tlast) begin
                        r_state       <= IDLE;
                        r_pkt_cnt_app <= r_pkt_cnt_app + 32'd1;
                    end
                end
                GRANT_ETH: begin
                    if (w_eth_fire && eth_tx_tlast) begin
                        r_state       <= IDLE;
                        r_pkt_cnt_eth <= r_pkt_cnt_eth + 32'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Two-entry buffer: head drives the core directly, tail holds the second beat.
    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head <= w_in;
                    end else begin
                        r_tail <= w_in;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    if (r_count == 2'd2) begin
                        r_head <= r_tail;
                    end
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head <= w_in;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= w_in;
                    end
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pcie_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcie_tx_arbiter
// Brief    : Randomised scoreboard bench for pcie_tx_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcie_tx_arbiter;

    localparam int c_dw = 64;
    localparam int c_kw = 8;

    logic            user_clk;
    logic            user_reset_n;
    logic            app_tx_tvalid, app_tx_tready, app_tx_tlast;
    logic [c_kw-1:0] app_tx_tkeep;
    logic [c_dw-1:0] app_tx_tdata;
    logic [3:0]      app_tx_tuser;
    logic            eth_tx_tvalid, eth_tx_tready, eth_tx_tlast;
    logic [c_kw-1:0] eth_tx_tkeep;
    logic [c_dw-1:0] eth_tx_tdata;
    logic [3:0]      eth_tx_tuser;
    logic            s_axis_tx_tready, s_axis_tx_tvalid, s_axis_tx_tlast;
    logic [c_kw-1:0] s_axis_tx_tkeep;
    logic [c_dw-1:0] s_axis_tx_tdata;
    logic [3:0]      s_axis_tx_tuser;
    logic [5:0]      tx_buf_av;
    logic [31:0]     pkt_cnt_app, pkt_cnt_eth;

    pcie_tx_arbiter dut (
        .user_clk         (user_clk),
        .user_reset_n     (user_reset_n),
        .app_tx_tvalid    (app_tx_tvalid),
        .app_tx_tready    (app_tx_tready),
        .app_tx_tlast     (app_tx_tlast),
        .app_tx_tkeep     (app_tx_tkeep),
        .app_tx_tdata     (app_tx_tdata),
        .app_tx_tuser     (app_tx_tuser),
        .eth_tx_tvalid    (eth_tx_tvalid),
        .eth_tx_tready    (eth_tx_tready),
        .eth_tx_tlast     (eth_tx_tlast),
        .eth_tx_tkeep     (eth_tx_tkeep),
        .eth_tx_tdata     (eth_tx_tdata),
        .eth_tx_tuser     (eth_tx_tuser),
        .s_axis_tx_tready (s_axis_tx_tready),
        .s_axis_tx_tvalid (s_axis_tx_tvalid),
        .s_axis_tx_tlast  (s_axis_tx_tlast),
        .s_axis_tx_tkeep  (s_axis_tx_tkeep),
        .s_axis_tx_tdata  (s_axis_tx_tdata),
        .s_axis_tx_tuser  (s_axis_tx_tuser),
        .tx_buf_av        (tx_buf_av),
        .pkt_cnt_app      (pkt_cnt_app),
        .pkt_cnt_eth      (pkt_cnt_eth)
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic [3:0]  user;
        logic        last;
    } beat_t;

    // Per-source stimulus queues and per-source expected-output queues.
    beat_t       app_q[$], eth_q[$], app_exp[$], eth_exp[$];
    int          n_tests, n_fail, cyc, occ, max_occ;
    logic [31:0] exp_cnt_app, exp_cnt_eth;
    bit          in_pkt, cur_src;
    int          app_gap, eth_gap, rdy_mode;
    bit          rand_buf;
    int          out_cyc[$], pkt_first[$], pkt_last[$];
    bit          pkt_src[$];

    task automatic reset_model();
        app_q.delete(); eth_q.delete(); app_exp.delete(); eth_exp.delete();
        out_cyc.delete(); pkt_first.delete(); pkt_last.delete(); pkt_src.delete();
        occ = 0; max_occ = 0; in_pkt = 0; cur_src = 0;
        exp_cnt_app = 32'd0; exp_cnt_eth = 32'd0;
    endtask

    task automatic make_pkt(input bit src, input int nbeats);
        beat_t b;
        for (int i = 0; i < nbeats; i++) begin
            b.data     = {$urandom, $urandom};
            b.data[63] = src;
            b.keep     = 8'($urandom);
            b.user     = 4'($urandom);
            b.last     = (i == nbeats - 1);
            if (src) begin eth_q.push_back(b); eth_exp.push_back(b); end
            else     begin app_q.push_back(b); app_exp.push_back(b); end
        end
    endtask

    task automatic drive();
        if (app_q.size() > 0 && $urandom_range(99) >= app_gap) begin
            app_tx_tvalid = 1'b1;
            {app_tx_tdata, app_tx_tkeep, app_tx_tuser, app_tx_tlast} = app_q[0];
        end else begin
            app_tx_tvalid = 1'b0;
        end
        if (eth_q.size() > 0 && $urandom_range(99) >= eth_gap) begin
            eth_tx_tvalid = 1'b1;
            {eth_tx_tdata, eth_tx_tkeep, eth_tx_tuser, eth_tx_tlast} = eth_q[0];
        end else begin
            eth_tx_tvalid = 1'b0;
        end
        case (rdy_mode)
            0:       s_axis_tx_tready = 1'b1;
            1:       s_axis_tx_tready = !s_axis_tx_tready;
            default: s_axis_tx_tready = 1'($urandom_range(1));
        endcase
        if (rand_buf) tx_buf_av = 6'($urandom_range(12));
    endtask

    task automatic monitor(input beat_t ob, input int c);
        beat_t e;
        bit    src;
        bit    have;
        src = ob.data[63];
        out_cyc.push_back(c);
        if (in_pkt) begin
            n_tests++;
            if (src !== cur_src) begin
                n_fail++;
                $display("FAIL interleave got src %0d want src %0d", src, cur_src);
            end
        end else begin
            pkt_first.push_back(c);
        end
        have = src ? (eth_exp.size() > 0) : (app_exp.size() > 0);
        n_tests++;
        if (!have) begin
            n_fail++;
            $display("FAIL unexpected_beat got %h want no beat", ob);
        end else begin
            if (src) e = eth_exp.pop_front();
            else     e = app_exp.pop_front();
            if (ob !== e) begin
                n_fail++;
                $display("FAIL beat_payload got %h want %h", ob, e);
            end
        end
        if (ob.last) begin
            in_pkt = 0;
            pkt_last.push_back(c);
            pkt_src.push_back(src);
        end else begin
            in_pkt  = 1;
            cur_src = src;
        end
    endtask

    // One clock cycle: sample handshakes away from the edge, then update the model.
    task automatic step();
        bit    af, ef, of;
        beat_t ob, b;
        int    c;
        #1;
        af = app_tx_tvalid && app_tx_tready;
        ef = eth_tx_tvalid && eth_tx_tready;
        of = s_axis_tx_tvalid && s_axis_tx_tready;
        ob = {s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tuser, s_axis_tx_tlast};
        n_tests++;
        if (app_tx_tready && eth_tx_tready) begin
            n_fail++;
            $display("FAIL both_tready got 1/1 want at most one");
        end
        n_tests++;
        if (occ == 2 && (app_tx_tready || eth_tx_tready)) begin
            n_fail++;
            $display("FAIL tready_at_full got app %0b eth %0b want 0/0", app_tx_tready, eth_tx_tready);
        end
        n_tests++;
        if (s_axis_tx_tvalid !== (occ != 0)) begin
            n_fail++;
            $display("FAIL out_valid got %0b want %0b (occ %0d)", s_axis_tx_tvalid, occ != 0, occ);
        end
        c = cyc;
        @(posedge user_clk);
        #1;
        cyc++;
        if (af) begin b = app_q.pop_front(); if (b.last) exp_cnt_app++; end
        if (ef) begin b = eth_q.pop_front(); if (b.last) exp_cnt_eth++; end
        occ = occ + int'(af) + int'(ef) - int'(of);
        if (occ > max_occ) max_occ = occ;
        if (of) monitor(ob, c);
        n_tests++;
        if (pkt_cnt_app !== exp_cnt_app || pkt_cnt_eth !== exp_cnt_eth) begin
            n_fail++;
            $display("FAIL pkt_cnt got %h/%h want %h/%h", pkt_cnt_app, pkt_cnt_eth, exp_cnt_app, exp_cnt_eth);
        end
        drive();
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while ((app_exp.size() > 0 || eth_exp.size() > 0) && n < max_cycles) begin
            step();
            n++;
        end
        n_tests++;
        if (app_exp.size() > 0 || eth_exp.size() > 0) begin
            n_fail++;
            $display("FAIL drain_timeout got %0d/%0d beats left want 0/0", app_exp.size(), eth_exp.size());
        end
        step();
        step();
    endtask

    task automatic apply_reset();
        user_reset_n     = 1'b0;
        app_tx_tvalid    = 1'b0; app_tx_tlast = 1'b0; app_tx_tkeep = '0; app_tx_tdata = '0; app_tx_tuser = '0;
        eth_tx_tvalid    = 1'b0; eth_tx_tlast = 1'b0; eth_tx_tkeep = '0; eth_tx_tdata = '0; eth_tx_tuser = '0;
        s_axis_tx_tready = 1'b1;
        tx_buf_av        = 6'd10;
        app_gap = 0; eth_gap = 0; rdy_mode = 0; rand_buf = 0;
        reset_model();
        repeat (2) @(posedge user_clk);
        #1;
        user_reset_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        user_reset_n = 1'b0;
        #1;
        n_tests++;
        if (app_tx_tready !== 1'b0 || eth_tx_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tready got %0b/%0b want 0/0", app_tx_tready, eth_tx_tready);
        end
        n_tests++;
        if (s_axis_tx_tvalid !== 1'b0 || s_axis_tx_tlast !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid_last got %0b/%0b want 0/0", s_axis_tx_tvalid, s_axis_tx_tlast);
        end
        n_tests++;
        if ({s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tuser} !== 76'd0) begin
            n_fail++;
            $display("FAIL reset_payload got %h/%h/%h want 0", s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tuser);
        end
        n_tests++;
        if (pkt_cnt_app !== 32'd0 || pkt_cnt_eth !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_cnt got %h/%h want 0/0", pkt_cnt_app, pkt_cnt_eth);
        end
        @(posedge user_clk);
        #1;
        user_reset_n = 1'b1;
        step();
        step();
    endtask

    task automatic test_single_app();
        int n0;
        apply_reset();
        make_pkt(1'b0, 3);
        drive();
        n0 = cyc;
        step();
        n_tests++;
        if (app_tx_tready !== 1'b1 || eth_tx_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL grant_latency got app %0b eth %0b want 1/0", app_tx_tready, eth_tx_tready);
        end
        drain(50);
        n_tests++;
        if (out_cyc.size() != 3 || out_cyc[0] != n0 + 2 || out_cyc[1] != n0 + 3 || out_cyc[2] != n0 + 4) begin
            n_fail++;
            $display("FAIL data_latency got %0d beats first at %0d want 3 beats at %0d..%0d",
                     out_cyc.size(), (out_cyc.size() > 0) ? out_cyc[0] - n0 : -1, 2, 4);
        end
        n_tests++;
        if (pkt_cnt_app !== 32'd1 || pkt_cnt_eth !== 32'd0) begin
            n_fail++;
            $display("FAIL single_cnt got %0d/%0d want 1/0", pkt_cnt_app, pkt_cnt_eth);
        end
    endtask

    task automatic test_round_robin();
        bit order_ok, gap_ok;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            make_pkt(1'b0, 2);
            make_pkt(1'b1, 2);
        end
        drive();
        drain(200);
        order_ok = (pkt_src.size() == 8);
        gap_ok   = (pkt_first.size() == 8 && pkt_last.size() == 8);
        for (int i = 0; i < 8 && order_ok; i++) begin
            if (pkt_src[i] != bit'(i % 2)) order_ok = 0;
        end
        for (int i = 1; i < 8 && gap_ok; i++) begin
            if (pkt_first[i] != pkt_last[i-1] + 2) gap_ok = 0;
        end
        n_tests++;
        if (!order_ok) begin
            n_fail++;
            $display("FAIL rr_order got %0d packets want 8 alternating APP/ETH", pkt_src.size());
        end
        n_tests++;
        if (!gap_ok) begin
            n_fail++;
            $display("FAIL rr_idle_gap got irregular packet spacing want exactly one idle cycle");
        end
        n_tests++;
        if (pkt_cnt_app !== 32'd4 || pkt_cnt_eth !== 32'd4) begin
            n_fail++;
            $display("FAIL rr_cnt got %0d/%0d want 4/4", pkt_cnt_app, pkt_cnt_eth);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        rdy_mode = 1;
        make_pkt(1'b1, 5);
        drive();
        drain(100);
        n_tests++;
        if (out_cyc.size() != 5 || pkt_cnt_eth !== 32'd1) begin
            n_fail++;
            $display("FAIL bp_delivery got %0d beats cnt %0d want 5 beats cnt 1", out_cyc.size(), pkt_cnt_eth);
        end
        n_tests++;
        if (max_occ != 2) begin
            n_fail++;
            $display("FAIL bp_fill got max occupancy %0d want 2", max_occ);
        end
    endtask

    task automatic test_buf_av();
        apply_reset();
        tx_buf_av = 6'd1;
        make_pkt(1'b0, 3);
        drive();
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++;
            if (app_tx_tready !== 1'b0 || out_cyc.size() != 0) begin
                n_fail++;
                $display("FAIL buf_av_hold got tready %0b beats %0d want 0/0", app_tx_tready, out_cyc.size());
            end
        end
        tx_buf_av = 6'd2;
        step();
        n_tests++;
        if (app_tx_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL buf_av_grant got tready %0b want 1", app_tx_tready);
        end
        tx_buf_av = 6'd0;
        drain(50);
        n_tests++;
        if (out_cyc.size() != 3 || pkt_cnt_app !== 32'd1) begin
            n_fail++;
            $display("FAIL buf_av_complete got %0d beats cnt %0d want 3 beats cnt 1", out_cyc.size(), pkt_cnt_app);
        end
    endtask

    task automatic test_reset_mid_packet();
        int n;
        apply_reset();
        make_pkt(1'b0, 4);
        drive();
        n = 0;
        while (app_q.size() > 3 && n < 20) begin
            step();
            n++;
        end
        n_tests++;
        if (app_q.size() != 3) begin
            n_fail++;
            $display("FAIL mid_reset_setup got %0d beats pending want 3", app_q.size());
        end
        #3;
        user_reset_n = 1'b0;
        #1;
        n_tests++;
        if ({app_tx_tready, eth_tx_tready, s_axis_tx_tvalid, s_axis_tx_tlast, s_axis_tx_tdata,
             s_axis_tx_tkeep, s_axis_tx_tuser, pkt_cnt_app, pkt_cnt_eth} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs got tv %0b rdy %0b/%0b data %h want all 0",
                     s_axis_tx_tvalid, app_tx_tready, eth_tx_tready, s_axis_tx_tdata);
        end
        reset_model();
        app_tx_tvalid = 1'b0;
        eth_tx_tvalid = 1'b0;
        @(posedge user_clk);
        #1;
        make_pkt(1'b1, 1);
        drive();
        user_reset_n = 1'b1;
        drain(50);
        n_tests++;
        if (pkt_cnt_eth !== 32'd1 || pkt_cnt_app !== 32'd0 || pkt_src.size() != 1) begin
            n_fail++;
            $display("FAIL mid_reset_after got cnt %0d/%0d pkts %0d want 0/1 pkts 1",
                     pkt_cnt_app, pkt_cnt_eth, pkt_src.size());
        end
    endtask

    task automatic test_counter_wrap();
        apply_reset();
        force dut.r_pkt_cnt_app = 32'hFFFF_FFFF;
        exp_cnt_app = 32'hFFFF_FFFF;
        @(posedge user_clk);
        #1;
        release dut.r_pkt_cnt_app;
        step();
        n_tests++;
        if (pkt_cnt_app !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL wrap_preload got %h want ffffffff", pkt_cnt_app);
        end
        make_pkt(1'b0, 1);
        drive();
        drain(50);
        n_tests++;
        if (pkt_cnt_app !== 32'd0) begin
            n_fail++;
            $display("FAIL wrap got %h want 00000000", pkt_cnt_app);
        end
    endtask

    task automatic test_random();
        int total;
        apply_reset();
        app_gap = 30; eth_gap = 30; rdy_mode = 2; rand_buf = 1;
        total = 0;
        for (int i = 0; i < 12; i++) begin
            int la, le;
            la = $urandom_range(6, 1);
            le = $urandom_range(6, 1);
            make_pkt(1'b0, la);
            make_pkt(1'b1, le);
            total += la + le;
        end
        drive();
        drain(6000);
        rand_buf  = 0;
        tx_buf_av = 6'd10;
        n_tests++;
        if (pkt_cnt_app !== 32'd12 || pkt_cnt_eth !== 32'd12 || out_cyc.size() != total) begin
            n_fail++;
            $display("FAIL random_totals got cnt %0d/%0d beats %0d want 12/12 beats %0d",
                     pkt_cnt_app, pkt_cnt_eth, out_cyc.size(), total);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got no completion want summary before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        test_reset();
        test_single_app();
        test_round_robin();
        test_backpressure();
        test_buf_av();
        test_reset_mid_packet();
        test_counter_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
